cpu_run_ctrl: RTL
=================

# cpu_run_ctrl

Synthesizable run controller that wraps the pipelined CPU's reset and execution window. On a start pulse it holds the core in reset for a programmable number of cycles, then enables it for at most `MAX_CYCLES` cycles. It ends the run early when the PC stays unchanged for `STALL_LIMIT` consecutive cycles, which detects a branch-to-self halt loop. It reports cycle count and completion cause, so benches and FPGA builds share one run/stop mechanism.

## Interface
Parameters:
- `PC_W`, 64, width of the monitored program counter
- `CNT_W`, 32, width of the cycle counter
- `RESET_CYCLES`, 1, cycles `core_reset` is held after start (≥1)
- `MAX_CYCLES`, 500, run budget in enabled cycles (≥1, < 2^CNT_W)
- `STALL_LIMIT`, 4, consecutive unchanged-PC compares that declare a halt (≥1)

Ports:
- `clk` in 1: single clock, all state on posedge
- `reset` in 1: asynchronous, active-high; forces all state to reset values immediately
- `start` in 1: sampled only in IDLE or DONE; begins a new run
- `pc` in PC_W: core's current fetch PC, valid while `core_en`=1
- `core_reset` out 1: reset to the CPU core
- `core_en` out 1: clock enable / run enable to the CPU core
- `running` out 1: state is RESET or RUN
- `done` out 1: state is DONE
- `halted` out 1: run ended by PC-stall detection (sticky until next start)
- `timeout` out 1: run ended by cycle budget (sticky until next start)
- `cycle_count` out CNT_W: number of RUN cycles in the current or last run

## Operation
- FSM states: IDLE, RESET, RUN, DONE. All outputs are Moore-decoded from registers.
- Reset values: state=IDLE, `core_reset`=1, `core_en`=0, `running`=0, `done`=0, `halted`=0, `timeout`=0, `cycle_count`=0, stall counter=0, `prev_pc`=0, `prev_valid`=0.
- IDLE: `core_reset`=1, `core_en`=0. If `start`=1 → RESET, with the reset counter loaded to RESET_CYCLES-1.
- RESET: `core_reset`=1, `core_en`=0. On a start edge from DONE, clears `cycle_count`, `halted`, `timeout`, the stall counter and `prev_valid`. Decrements the counter; on the edge where it is 0 → RUN. `start` is ignored.
- RUN: `core_reset`=0, `core_en`=1. Each edge:
  - `cycle_count` += 1.
  - If `prev_valid` and `pc`==`prev_pc`, the stall counter += 1; otherwise the stall counter = 0.
  - `prev_pc`←`pc`, `prev_valid`←1.
  - `start` is ignored.
- RUN exit, evaluated on the same edge using the next-values:
  - If the stall counter's next value equals STALL_LIMIT → DONE, `halted`←1.
  - Else if `cycle_count`'s next value equals MAX_CYCLES → DONE, `timeout`←1.
  - If both hold on the same edge, only `halted` is set.
- DONE: `core_reset`=0, `core_en`=0, so core state is frozen for inspection. `done`=1, and the flags and `cycle_count` are held. `start`=1 → RESET, clearing the flags and counters.
- First RUN cycle never counts as a stall, because `prev_valid`=0.
- Counters are unsigned and never wrap: the MAX_CYCLES bound guarantees `cycle_count` < 2^CNT_W.

## Timing
- `start` high at edge k in IDLE → `core_reset`=1 through edge k+RESET_CYCLES. `core_en` rises after edge k+RESET_CYCLES.
- With no halt, `core_en` is high for exactly MAX_CYCLES cycles. `done` rises on the edge where `cycle_count` becomes MAX_CYCLES.
- Halt: with a constant `pc` from the first RUN cycle, `done` rises after STALL_LIMIT+1 RUN edges, and `cycle_count`=STALL_LIMIT+1.
- Async `reset` mid-RUN: outputs return to reset values without waiting for a clock edge. Deassertion is synchronised externally; the block needs no extra cycle.
- Start-to-restart from DONE: the same latency as from IDLE.

## Test plan
- Reset in, defaults, `start` pulse, `pc` incrementing by 4 → `core_reset` for 1 cycle, `core_en` for 500 cycles, then `done`=1, `timeout`=1, `halted`=0, `cycle_count`=500.
- RESET_CYCLES=3, `pc` stuck at 0x40 from RUN entry → `core_reset` high 3 cycles after start, `done` after 5 RUN cycles, `halted`=1, `cycle_count`=5.
- MAX_CYCLES=5, STALL_LIMIT=4, constant `pc` → halt and budget coincide on edge 5 → `halted`=1, `timeout`=0.
- `pc` repeats 3 times, changes, then repeats 4 times (STALL_LIMIT=4) → the stall counter clears on the change; halt is declared only after the second run of repeats.
- `start` pulsed during RUN → ignored, `cycle_count` unaffected. `start` in DONE → flags clear, `cycle_count`=0, new run proceeds.
- Async `reset` asserted between edges mid-RUN → `core_reset`=1, `core_en`=0, and all status 0 immediately. Release and `start` → normal run.

Source files
------------

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: run/stop controller for the pipelined CPU.
// Holds the core in reset after a start, enables it for a bounded number
// of cycles, and stops early when the fetch PC sits still (halt loop).
module cpu_run_ctrl #(
  parameter int PC_W         = 64,
  parameter int CNT_W        = 32,
  parameter int RESET_CYCLES = 1,
  parameter int MAX_CYCLES   = 500,
  parameter int STALL_LIMIT  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [PC_W-1:0]  pc,
  output logic             core_reset,
  output logic             core_en,
  output logic             running,
  output logic             done,
  output logic             halted,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_count
);

  localparam int RC_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam int SL_W = $clog2(STALL_LIMIT + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RESET = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [RC_W-1:0]  rst_cnt, rst_cnt_nxt;
  logic [SL_W-1:0]  stall_cnt, stall_cnt_nxt;
  logic [PC_W-1:0]  prev_pc, prev_pc_nxt;
  logic             prev_valid, prev_valid_nxt;
  logic             halted_q, halted_nxt;
  logic             timeout_q, timeout_nxt;
  logic [CNT_W-1:0] cycle_q, cycle_nxt;

  // State and datapath registers, asynchronously reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      rst_cnt    <= '0;
      stall_cnt  <= '0;
      prev_pc    <= '0;
      prev_valid <= 1'b0;
      halted_q   <= 1'b0;
      timeout_q  <= 1'b0;
      cycle_q    <= '0;
    end else begin
      state      <= state_nxt;
      rst_cnt    <= rst_cnt_nxt;
      stall_cnt  <= stall_cnt_nxt;
      prev_pc    <= prev_pc_nxt;
      prev_valid <= prev_valid_nxt;
      halted_q   <= halted_nxt;
      timeout_q  <= timeout_nxt;
      cycle_q    <= cycle_nxt;
    end
  end

  // Next-state and next-value logic; run status is cleared on the start
  // edge itself so it already reads zero during the RESET window.
  always_comb begin
    state_nxt      = state;
    rst_cnt_nxt    = rst_cnt;
    stall_cnt_nxt  = stall_cnt;
    prev_pc_nxt    = prev_pc;
    prev_valid_nxt = prev_valid;
    halted_nxt     = halted_q;
    timeout_nxt    = timeout_q;
    cycle_nxt      = cycle_q;
    unique case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_nxt      = S_RESET;
          rst_cnt_nxt    = RC_W'(RESET_CYCLES - 1);
          cycle_nxt      = '0;
          halted_nxt     = 1'b0;
          timeout_nxt    = 1'b0;
          stall_cnt_nxt  = '0;
          prev_valid_nxt = 1'b0;
        end
      end
      S_RESET: begin
        if (rst_cnt == '0) state_nxt = S_RUN;
        else               rst_cnt_nxt = rst_cnt - RC_W'(1);
      end
      S_RUN: begin
        cycle_nxt = cycle_q + CNT_W'(1);
        if (prev_valid && (pc == prev_pc)) stall_cnt_nxt = stall_cnt + SL_W'(1);
        else                               stall_cnt_nxt = '0;
        prev_pc_nxt    = pc;
        prev_valid_nxt = 1'b1;
        // Halt takes priority when both exit conditions land on one edge.
        if (stall_cnt_nxt == SL_W'(STALL_LIMIT)) begin
          state_nxt  = S_DONE;
          halted_nxt = 1'b1;
        end else if (cycle_nxt == CNT_W'(MAX_CYCLES)) begin
          state_nxt   = S_DONE;
          timeout_nxt = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Moore outputs decoded from registered state.
  always_comb begin
    core_reset  = (state == S_IDLE) || (state == S_RESET);
    core_en     = (state == S_RUN);
    running     = (state == S_RESET) || (state == S_RUN);
    done        = (state == S_DONE);
    halted      = halted_q;
    timeout     = timeout_q;
    cycle_count = cycle_q;
  end

endmodule
